// File: rtl/plb_port_arbiter.sv
// plb_port_arbiter
// Shares one PLB cache MEM port (req/gnt/valid) between NUM_REQ requesters.
// Arbitration is round-robin with a lock that keeps the selection stable while
// the PLB stalls a request. An in-order ID FIFO records which requester owns
// each granted transaction so its response can be routed back.

module plb_port_arbiter #(
   parameter int NUM_REQ         = 2,
   parameter int DATA_WIDTH      = 64,
   parameter int ADDR_WIDTH      = 64,
   parameter int MAX_OUTSTANDING = 4,
   localparam int IDW            = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int CW             = $clog2(MAX_OUTSTANDING + 1),
   localparam int BW             = DATA_WIDTH / 8
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   // requester side
   input  logic [NUM_REQ-1:0]            s_mem_req,
   output logic [NUM_REQ-1:0]            s_mem_gnt,
   output logic [NUM_REQ-1:0]            s_mem_valid,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_mem_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] s_mem_wdata,
   input  logic [NUM_REQ-1:0]            s_mem_we,
   input  logic [NUM_REQ*BW-1:0]         s_mem_be,
   output logic [NUM_REQ*DATA_WIDTH-1:0] s_mem_rdata,
   output logic [NUM_REQ-1:0]            s_mem_error,
   // PLB side
   output logic                          m_mem_req,
   input  logic                          m_mem_gnt,
   input  logic                          m_mem_valid,
   output logic [ADDR_WIDTH-1:0]         m_mem_addr,
   output logic [DATA_WIDTH-1:0]         m_mem_wdata,
   output logic                          m_mem_we,
   output logic [BW-1:0]                 m_mem_be,
   input  logic [DATA_WIDTH-1:0]         m_mem_rdata,
   input  logic                          m_mem_error,
   // status
   output logic [CW-1:0]                 outstanding_o,
   output logic                          spurious_err_o
);

   // FIFO pointer width; a depth of one still needs a one-bit pointer.
   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam logic [CW-1:0] MAX_CNT   = CW'(MAX_OUTSTANDING);
   localparam logic [PW-1:0] LAST_SLOT = PW'(MAX_OUTSTANDING - 1);

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [IDW-1:0] rr_ptr_r;
   logic           lock_r;
   logic [IDW-1:0] sel_r;
   logic [CW-1:0]  count_r;
   logic [PW-1:0]  rd_ptr_r;
   logic [PW-1:0]  wr_ptr_r;
   logic           spurious_r;
   logic [IDW-1:0] id_fifo_r [MAX_OUTSTANDING];

   // ------------------------------------------------------------------
   // Combinational signals
   // ------------------------------------------------------------------
   logic [IDW-1:0] rr_winner_s;
   logic [IDW-1:0] winner_s;
   logic           full_s;
   logic           handshake_s;
   logic           pop_s;
   logic           spurious_rsp_s;
   logic [IDW-1:0] head_id_s;
   logic [PW-1:0]  rd_ptr_next_s;
   logic [PW-1:0]  wr_ptr_next_s;

   // Pointer increment that wraps at the FIFO depth (depth need not fill PW bits).
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
      logic [PW-1:0] nxt;
      if (ptr == LAST_SLOT) begin
         nxt = {PW{1'b0}};
      end else begin
         nxt = ptr + {{(PW-1){1'b0}}, 1'b1};
      end
      return nxt;
   endfunction

   // Round-robin (winner+1) mod NUM_REQ for the pointer after a handshake.
   function automatic logic [IDW-1:0] id_inc(input logic [IDW-1:0] id);
      logic [IDW-1:0] nxt;
      if (id == IDW'(NUM_REQ - 1)) begin
         nxt = {IDW{1'b0}};
      end else begin
         nxt = id + {{(IDW-1){1'b0}}, 1'b1};
      end
      return nxt;
   endfunction

   // Round-robin search starting at rr_ptr; the closest requesting index wins.
   always_comb begin
      rr_winner_s = rr_ptr_r;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin : rr_search
         logic [IDW:0] sum_v;
         logic [IDW-1:0] idx_v;
         sum_v = {1'b0, rr_ptr_r} + (IDW+1)'(k);
         if (sum_v >= (IDW+1)'(NUM_REQ)) begin
            sum_v = sum_v - (IDW+1)'(NUM_REQ);
         end else begin
            sum_v = sum_v;
         end
         idx_v = sum_v[IDW-1:0];
         if (s_mem_req[idx_v]) begin
            rr_winner_s = idx_v;
         end else begin
            rr_winner_s = rr_winner_s;
         end
      end
   end

   // A locked selection overrides arbitration so a stalled request stays put.
   always_comb begin
      if (lock_r) begin
         winner_s = sel_r;
      end else begin
         winner_s = rr_winner_s;
      end
   end

   // Request forwarding and grant steering, zero-cycle path.
   always_comb begin
      full_s      = (count_r == MAX_CNT);
      m_mem_req   = s_mem_req[winner_s] & ~full_s;
      handshake_s = m_mem_req & m_mem_gnt;
      m_mem_addr  = {ADDR_WIDTH{1'b0}};
      m_mem_wdata = {DATA_WIDTH{1'b0}};
      m_mem_we    = 1'b0;
      m_mem_be    = {BW{1'b0}};
      s_mem_gnt   = {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner_s == IDW'(i)) begin
            m_mem_addr   = s_mem_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            m_mem_wdata  = s_mem_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            m_mem_we     = s_mem_we[i];
            m_mem_be     = s_mem_be[i*BW +: BW];
            s_mem_gnt[i] = handshake_s;
         end else begin
            s_mem_gnt[i] = 1'b0;
         end
      end
   end

   // Response routing: the FIFO head owns the response; rdata goes to everyone.
   always_comb begin
      head_id_s      = id_fifo_r[rd_ptr_r];
      pop_s          = m_mem_valid & (count_r != {CW{1'b0}});
      spurious_rsp_s = m_mem_valid & (count_r == {CW{1'b0}});
      s_mem_valid    = {NUM_REQ{1'b0}};
      s_mem_error    = {NUM_REQ{1'b0}};
      for (int i = 0; i < NUM_REQ; i++) begin
         if (pop_s && (head_id_s == IDW'(i))) begin
            s_mem_valid[i] = 1'b1;
            s_mem_error[i] = m_mem_error;
         end else begin
            s_mem_valid[i] = 1'b0;
            s_mem_error[i] = 1'b0;
         end
      end
      s_mem_rdata = {NUM_REQ{m_mem_rdata}};
   end

   // Next FIFO pointer values.
   always_comb begin
      if (pop_s) begin
         rd_ptr_next_s = ptr_inc(rd_ptr_r);
      end else begin
         rd_ptr_next_s = rd_ptr_r;
      end
      if (handshake_s) begin
         wr_ptr_next_s = ptr_inc(wr_ptr_r);
      end else begin
         wr_ptr_next_s = wr_ptr_r;
      end
   end

   // Arbitration state, lock, outstanding count and the sticky spurious flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_r   <= {IDW{1'b0}};
         lock_r     <= 1'b0;
         sel_r      <= {IDW{1'b0}};
         count_r    <= {CW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         wr_ptr_r   <= {PW{1'b0}};
         spurious_r <= 1'b0;
      end else begin
         rd_ptr_r <= rd_ptr_next_s;
         wr_ptr_r <= wr_ptr_next_s;

         if (handshake_s) begin
            rr_ptr_r <= id_inc(winner_s);
            lock_r   <= 1'b0;
         end else if (m_mem_req || (full_s && s_mem_req[winner_s])) begin
            // stalled by the PLB or by the outstanding limit: hold the choice
            lock_r <= 1'b1;
            sel_r  <= winner_s;
         end else begin
            lock_r <= lock_r;
         end

         if (handshake_s && !pop_s) begin
            count_r <= count_r + {{(CW-1){1'b0}}, 1'b1};
         end else if (pop_s && !handshake_s) begin
            count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
         end else begin
            count_r <= count_r;
         end

         if (spurious_rsp_s) begin
            spurious_r <= 1'b1;
         end else begin
            spurious_r <= spurious_r;
         end
      end
   end

   // ID FIFO storage: record the owner of each granted transaction.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            id_fifo_r[i] <= {IDW{1'b0}};
         end
      end else if (handshake_s) begin
         id_fifo_r[wr_ptr_r] <= winner_s;
      end else begin
         id_fifo_r[wr_ptr_r] <= id_fifo_r[wr_ptr_r];
      end
   end

   assign outstanding_o  = count_r;
   assign spurious_err_o = spurious_r;

   plb_port_arbiter_chk #(
      .NUM_REQ         (NUM_REQ),
      .MAX_OUTSTANDING (MAX_OUTSTANDING),
      .CW              (CW)
   ) u_chk (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .s_mem_gnt   (s_mem_gnt),
      .s_mem_valid (s_mem_valid),
      .count       (count_r)
   );

endmodule

// Structural invariants of the arbiter: at most one grant and one response
// per cycle, and the in-flight count never passes the limit.
module plb_port_arbiter_chk #(
   parameter int NUM_REQ         = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter int CW              = 3
) (
   input logic               clk_i,
   input logic               rst_i,
   input logic [NUM_REQ-1:0] s_mem_gnt,
   input logic [NUM_REQ-1:0] s_mem_valid,
   input logic [CW-1:0]      count
);

   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

   a_gnt_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(s_mem_gnt));
   a_valid_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(s_mem_valid));
   a_count_limit: assert property (@(posedge clk_i) disable iff (rst_i) count <= MAX_CNT);

endmodule

// File: tb/tb_plb_port_arbiter.sv
// Directed, table-driven bench for plb_port_arbiter (NUM_REQ=2, MAX_OUTSTANDING=4).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.

module tb_plb_port_arbiter;

   logic          clk;
   logic          rst_i;
   logic [1:0]    s_mem_req;
   logic [1:0]    s_mem_gnt;
   logic [1:0]    s_mem_valid;
   logic [127:0]  s_mem_addr;
   logic [127:0]  s_mem_wdata;
   logic [1:0]    s_mem_we;
   logic [15:0]   s_mem_be;
   logic [127:0]  s_mem_rdata;
   logic [1:0]    s_mem_error;
   logic          m_mem_req;
   logic          m_mem_gnt;
   logic          m_mem_valid;
   logic [63:0]   m_mem_addr;
   logic [63:0]   m_mem_wdata;
   logic          m_mem_we;
   logic [7:0]    m_mem_be;
   logic [63:0]   m_mem_rdata;
   logic          m_mem_error;
   logic [2:0]    outstanding_o;
   logic          spurious_err_o;

   int tests_run;
   int tests_failed;

   plb_port_arbiter dut (
      .clk_i          (clk),
      .rst_i          (rst_i),
      .s_mem_req      (s_mem_req),
      .s_mem_gnt      (s_mem_gnt),
      .s_mem_valid    (s_mem_valid),
      .s_mem_addr     (s_mem_addr),
      .s_mem_wdata    (s_mem_wdata),
      .s_mem_we       (s_mem_we),
      .s_mem_be       (s_mem_be),
      .s_mem_rdata    (s_mem_rdata),
      .s_mem_error    (s_mem_error),
      .m_mem_req      (m_mem_req),
      .m_mem_gnt      (m_mem_gnt),
      .m_mem_valid    (m_mem_valid),
      .m_mem_addr     (m_mem_addr),
      .m_mem_wdata    (m_mem_wdata),
      .m_mem_we       (m_mem_we),
      .m_mem_be       (m_mem_be),
      .m_mem_rdata    (m_mem_rdata),
      .m_mem_error    (m_mem_error),
      .outstanding_o  (outstanding_o),
      .spurious_err_o (spurious_err_o)
   );

   // free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [1:0]  req;
      logic        gnt;
      logic        val;
      logic [15:0] rdata;
      logic        err;
      logic        chk;
      logic        e_mreq;
      logic [1:0]  e_gnt;
      logic [1:0]  e_valid;
      logic [1:0]  e_err;
      logic [15:0] e_addr;
      logic [2:0]  e_out;
      logic        e_spur;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic rst, logic [1:0] req, logic gnt, logic val,
                               logic [15:0] rd, logic err, logic chk,
                               logic mreq, logic [1:0] sg, logic [1:0] sv,
                               logic [1:0] se, logic [15:0] ad, logic [2:0] oc,
                               logic sp);
      vec_t v;
      v.rst = rst; v.req = req; v.gnt = gnt; v.val = val; v.rdata = rd; v.err = err;
      v.chk = chk; v.e_mreq = mreq; v.e_gnt = sg; v.e_valid = sv; v.e_err = se;
      v.e_addr = ad; v.e_out = oc; v.e_spur = sp;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_vec(input int n, input vec_t v);
      logic [63:0] exp_addr;
      logic [63:0] exp_wdata;
      logic        exp_we;
      logic [7:0]  exp_be;
      logic [63:0] exp_rd;
      logic        bad;
      exp_addr  = {48'h0, v.e_addr};
      exp_we    = (v.e_addr == 16'h2000);
      exp_wdata = exp_we ? 64'h1D1D : 64'h0D0D;
      exp_be    = exp_we ? 8'hF0 : 8'h0F;
      exp_rd    = {48'h0, v.rdata};
      bad = (m_mem_req !== v.e_mreq) || (s_mem_gnt !== v.e_gnt) ||
            (s_mem_valid !== v.e_valid) || (s_mem_error !== v.e_err) ||
            (m_mem_addr !== exp_addr) || (m_mem_wdata !== exp_wdata) ||
            (m_mem_we !== exp_we) || (m_mem_be !== exp_be) ||
            (s_mem_rdata[63:0] !== exp_rd) || (s_mem_rdata[127:64] !== exp_rd) ||
            (outstanding_o !== v.e_out) || (spurious_err_o !== v.e_spur);
      tests_run++;
      if (bad) begin
         tests_failed++;
         $display("FAIL vec%0d: got mreq=%b gnt=%b valid=%b err=%b addr=%0h we=%b out=%0d spur=%b expected mreq=%b gnt=%b valid=%b err=%b addr=%0h we=%b out=%0d spur=%b",
                  n, m_mem_req, s_mem_gnt, s_mem_valid, s_mem_error, m_mem_addr, m_mem_we,
                  outstanding_o, spurious_err_o, v.e_mreq, v.e_gnt, v.e_valid, v.e_err,
                  exp_addr, exp_we, v.e_out, v.e_spur);
      end
   endtask

   initial begin
      logic granted;
      tests_run    = 0;
      tests_failed = 0;
      rst_i        = 1'b1;
      s_mem_req    = 2'b00;
      s_mem_addr   = {64'h2000, 64'h1000};
      s_mem_wdata  = {64'h1D1D, 64'h0D0D};
      s_mem_we     = 2'b10;
      s_mem_be     = {8'hF0, 8'h0F};
      m_mem_gnt    = 1'b0;
      m_mem_valid  = 1'b0;
      m_mem_rdata  = 64'h0;
      m_mem_error  = 1'b0;

      //                 rst   req    gnt   val   rdata     err   chk    mreq  gnt    valid  err    addr      out   spur
      // reset
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 16'h1000, 3'd0, 1'b0));
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 16'h1000, 3'd0, 1'b0));
      // single requester
      vecs.push_back(mk(1'b0, 2'b01, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 16'h1000, 3'd0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 16'h2000, 3'd1, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, 16'hABCD, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 16'h2000, 3'd1, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 16'h2000, 3'd0, 1'b0));
      // lock: rr_ptr=1, requester 0 stalled, requester 1 joins
      vecs.push_back(mk(1'b0, 2'b01, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 16'h1000, 3'd0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b11, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 16'h1000, 3'd0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b11, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 16'h1000, 3'd0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 16'h1000, 3'd0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b10, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00, 16'h2000, 3'd1, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 16'h1000, 3'd2, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, 16'h6666, 1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b10, 16'h1000, 3'd1, 1'b0));
      // reset, then contention with simultaneous push/pop
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 16'h1000, 3'd0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 16'h1000, 3'd0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b10, 2'b00, 2'b00, 16'h2000, 3'd1, 1'b0));
      vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, 16'h1111, 1'b0, 1'b1, 1'b1, 2'b01, 2'b01, 2'b00, 16'h1000, 3'd2, 1'b0));
      vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, 16'h2222, 1'b1, 1'b1, 1'b1, 2'b10, 2'b10, 2'b10, 16'h2000, 3'd2, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, 16'h3333, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 16'h1000, 3'd2, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, 16'h4444, 1'b0, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 16'h1000, 3'd1, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 16'h1000, 3'd0, 1'b0));
      // outstanding limit
      vecs.push_back(mk(1'b0, 2'b01, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 16'h1000, 3'd0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 16'h1000, 3'd1, 1'b0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 16'h1000, 3'd2, 1'b0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 16'h1000, 3'd3, 1'b0));
      vecs.push_back(mk(1'b0, 2'b01, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 16'h1000, 3'd4, 1'b0));
      vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b1, 16'h7777, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, 2'b00, 16'h1000, 3'd4, 1'b0));
      vecs.push_back(mk(1'b0, 2'b11, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 16'h1000, 3'd3, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 16'h2000, 3'd4, 1'b0));
      // reset with transactions in flight, then spurious responses
      vecs.push_back(mk(1'b1, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 16'h2000, 3'd4, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b1, 16'h8888, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 16'h1000, 3'd0, 1'b0));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 16'h1000, 3'd0, 1'b1));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 16'h1000, 3'd0, 1'b1));
      vecs.push_back(mk(1'b0, 2'b01, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 16'h1000, 3'd0, 1'b1));
      vecs.push_back(mk(1'b0, 2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 16'h2000, 3'd1, 1'b1));

      foreach (vecs[n]) begin
         @(negedge clk);
         rst_i       = vecs[n].rst;
         s_mem_req   = vecs[n].req;
         m_mem_gnt   = vecs[n].gnt;
         m_mem_valid = vecs[n].val;
         m_mem_rdata = {48'h0, vecs[n].rdata};
         m_mem_error = vecs[n].err;
         #1;
         if (vecs[n].chk) begin
            check_vec(n, vecs[n]);
         end
      end

      // drain the one transaction left from the table (owned by requester 0)
      @(negedge clk);
      s_mem_req   = 2'b00;
      m_mem_gnt   = 1'b0;
      m_mem_valid = 1'b1;
      m_mem_rdata = 64'hCAFE;
      #1;
      chk("drain_valid", {62'h0, s_mem_valid}, 64'h1);
      chk("drain_out", {61'h0, outstanding_o}, 64'h1);

      // requester 1 waits out two stalled cycles; grant bounded to 8 cycles
      granted = 1'b0;
      for (int c = 0; c < 8 && !granted; c++) begin
         @(negedge clk);
         m_mem_valid = 1'b0;
         s_mem_req   = 2'b10;
         m_mem_gnt   = (c >= 2) ? 1'b1 : 1'b0;
         #1;
         if (s_mem_gnt[1]) begin
            granted = 1'b1;
            chk("h_grant_addr", m_mem_addr, 64'h2000);
            chk("h_grant_cycle", 64'(c), 64'd2);
         end
      end
      chk("h_granted", {63'h0, granted}, 64'h1);

      // response for requester 1 with error, then count back to zero
      @(negedge clk);
      s_mem_req   = 2'b00;
      m_mem_gnt   = 1'b0;
      m_mem_valid = 1'b1;
      m_mem_error = 1'b1;
      m_mem_rdata = 64'hBEEF;
      #1;
      chk("h_valid", {62'h0, s_mem_valid}, 64'h2);
      chk("h_error", {62'h0, s_mem_error}, 64'h2);
      chk("h_rdata1", s_mem_rdata[127:64], 64'hBEEF);
      chk("h_out_before", {61'h0, outstanding_o}, 64'h1);

      @(negedge clk);
      m_mem_valid = 1'b0;
      m_mem_error = 1'b0;
      #1;
      chk("h_out_after", {61'h0, outstanding_o}, 64'h0);
      chk("h_spur_sticky", {63'h0, spurious_err_o}, 64'h1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/plb_port_arbiter.md
Name: plb_port_arbiter

Overview:
- Shares the single PLB cache MEM/SRAM port (req/gnt/valid protocol) between NUM_REQ requesters, e.g. the PLB lookup stage (reads) and the PLB refill/invalidate logic (writes).
- Round-robin arbitration on the request phase; tracks in-flight transactions in order and routes each response (valid/rdata/error) back to its originator.
- Sits between the walker's PLB-facing stages and the PLB cache.

Parameters:
- NUM_REQ, 2, number of requester ports (≥2).
- DATA_WIDTH, 64, MEM data width.
- ADDR_WIDTH, 64, MEM address width (PLB tag).
- MAX_OUTSTANDING, 4, maximum granted-but-unanswered transactions (power of 2, ≥1).
- Derived: IDW = max(1, $clog2(NUM_REQ)); CW = $clog2(MAX_OUTSTANDING+1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- s_mem_req  in  NUM_REQ  per-requester request.
- s_mem_gnt  out  NUM_REQ  per-requester grant.
- s_mem_valid  out  NUM_REQ  per-requester response valid.
- s_mem_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice i.
- s_mem_wdata  in  NUM_REQ*DATA_WIDTH  packed write data.
- s_mem_we  in  NUM_REQ  write enable.
- s_mem_be  in  NUM_REQ*DATA_WIDTH/8  byte enables.
- s_mem_rdata  out  NUM_REQ*DATA_WIDTH  packed read data.
- s_mem_error  out  NUM_REQ  response error.
- m_mem_req  out  1  request to PLB.
- m_mem_gnt  in  1  grant from PLB.
- m_mem_valid  in  1  response valid from PLB.
- m_mem_addr  out  ADDR_WIDTH  forwarded address.
- m_mem_wdata  out  DATA_WIDTH  forwarded write data.
- m_mem_we  out  1  forwarded write enable.
- m_mem_be  out  DATA_WIDTH/8  forwarded byte enables.
- m_mem_rdata  in  DATA_WIDTH  read data from PLB.
- m_mem_error  in  1  error from PLB.
- outstanding_o  out  CW  in-flight transaction count.
- spurious_err_o  out  1  sticky: response received with no transaction in flight.

Behaviour:
- Reset (rst_i high at a clk_i edge): rr_ptr=0, lock=0, sel=0, count=0, ID FIFO rd/wr pointers=0, spurious_err_o=0. All s_mem_gnt/s_mem_valid/s_mem_error=0; m_mem_req=0. Reset mid-transaction discards all in-flight IDs; responses arriving afterwards count as spurious.
- Arbitration, combinational:
  - If lock=1, winner=sel.
  - Otherwise winner = first i with s_mem_req[i]=1, searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
- Forwarding:
  - m_mem_req = s_mem_req[winner] & (count<MAX_OUTSTANDING).
  - m_mem_addr/wdata/we/be = slice[winner].
  - s_mem_gnt[winner] = m_mem_gnt & m_mem_req; all other gnt bits are 0.
  - Zero-cycle path; no added request latency.
- Lock (protocol stability):
  - If m_mem_req=1 and m_mem_gnt=0, set lock=1 and sel=winner. The winner's request fields must stay stable, per the MEM protocol.
  - If count=MAX_OUTSTANDING and the winner is requesting, set lock=1 and sel=winner, so the selection is held while stalled.
  - Lock clears on handshake.
- Handshake (m_mem_req & m_mem_gnt):
  - Push winner ID into the ID FIFO (depth MAX_OUTSTANDING).
  - rr_ptr ← (winner+1) mod NUM_REQ; lock ← 0.
- Response (m_mem_valid=1, count>0):
  - Pop head ID h.
  - s_mem_valid[h]=1, s_mem_error[h]=m_mem_error, same cycle (combinational).
  - s_mem_rdata: every slice carries m_mem_rdata; consumers qualify with their own s_mem_valid.
- Response with count=0: no s_mem_valid asserted; spurious_err_o←1, sticky until reset. A response in the same cycle as the first handshake is spurious, because responses arrive ≥1 cycle after grant.
- Count:
  - +1 on handshake only; −1 on valid-pop only.
  - Handshake and valid-pop in the same cycle: count unchanged, push and pop both performed.
  - count never exceeds MAX_OUTSTANDING; FIFO pointers wrap modulo MAX_OUTSTANDING.
- outstanding_o = count, registered.
- Responses return in grant order; the PLB is required to respond in order.

Test Plan:
- Single requester: s_mem_req[0]=1, addr=0x1000, m_mem_gnt=1 in the same cycle → s_mem_gnt=2'b01 in that cycle, outstanding_o=1 next cycle; m_mem_valid with rdata=0xABCD two cycles later → s_mem_valid=2'b01, slice0 rdata=0xABCD, outstanding_o=0.
- Contention: both requesters request every cycle, gnt=1 always → grants alternate 01,10,01,10 starting with requester 0 after reset; responses route to the matching IDs in order.
- Lock: req0=1 and m_mem_gnt=0 for 3 cycles, req1 raised in cycle 2 → m_mem_addr stays on requester 0 for all 3 cycles; requester 1 is granted only after requester 0's handshake.
- Outstanding limit: MAX_OUTSTANDING=4, gnt=1, no valid → 4 grants, then m_mem_req=0 with outstanding_o=4. One valid pulse together with a pending request → handshake in the next cycle, outstanding_o stays 4.
- Simultaneous push/pop: at count=2, handshake and valid in the same cycle → count stays 2; the popped ID is the oldest.
- Spurious/reset: 2 in flight, rst_i pulsed, then m_mem_valid=1 → no s_mem_valid asserted, spurious_err_o=1, outstanding_o=0.
